dvi_timing_gen: RTL and testbench

DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

---
 rtl/dvi_timing_gen.sv | 219 +++++++++++++++++++++
 tb/tb_dvi_timing_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_gen.sv
// DVI/HDMI raster timing generator with stream, colour-bar, solid and black sources.
// Outputs are registered one cycle behind the raster position; `enable` low freezes everything.
module dvi_timing_gen #(
  parameter int H_ACTIVE      = 1280,
  parameter int H_FRONT_PORCH = 110,
  parameter int H_SYNC        = 40,
  parameter int H_BACK_PORCH  = 220,
  parameter int V_ACTIVE      = 720,
  parameter int V_FRONT_PORCH = 5,
  parameter int V_SYNC        = 5,
  parameter int V_BACK_PORCH  = 20,
  parameter bit HS_POLARITY   = 1'b1,
  parameter bit VS_POLARITY   = 1'b1,
  parameter int PIXEL_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [PIXEL_WIDTH-1:0] solid_color,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  input  logic                   s_sof,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   de,
  output logic                   hs,
  output logic                   vs,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   frame_start,
  output logic                   underflow,
  output logic                   sof_error,
  input  logic                   underflow_clr
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > d) ? m : d;
  endfunction

  localparam int CW    = PIXEL_WIDTH / 3;
  localparam int HCW   = $clog2(max4(H_ACTIVE, H_FRONT_PORCH, H_SYNC, H_BACK_PORCH) + 1);
  localparam int VCW   = $clog2(max4(V_ACTIVE, V_FRONT_PORCH, V_SYNC, V_BACK_PORCH) + 1);
  localparam int BCW   = $clog2(H_ACTIVE + 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

  // Segment codes are in raster order so the next segment is simply +1.
  localparam logic [1:0] SEG_BP = 2'd0, SEG_ACT = 2'd1, SEG_FP = 2'd2, SEG_SYNC = 2'd3;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  logic [HCW-1:0]         h_cnt_reg, h_end;
  logic [VCW-1:0]         v_cnt_reg, v_end;
  logic [1:0]             h_seg_reg, v_seg_reg, mode_reg;
  logic [BCW-1:0]         bar_cnt_reg;
  logic [2:0]             bar_idx_reg;
  lock_state_t            state_reg, state_next;
  logic                   h_last, v_last, line_end, frame_end;
  logic                   active, first, stream, sof_beat;
  logic                   take_pixel, set_uf, set_se;
  logic [PIXEL_WIDTH-1:0] bar_pixel, pixel_next;
  logic                   de_reg, hs_reg, vs_reg, frame_start_reg, underflow_reg, sof_error_reg;
  logic [PIXEL_WIDTH-1:0] pixel_reg;

  always_comb begin
    case (h_seg_reg)
      SEG_BP:  h_end = HCW'(H_BACK_PORCH - 1);
      SEG_ACT: h_end = HCW'(H_ACTIVE - 1);
      SEG_FP:  h_end = HCW'(H_FRONT_PORCH - 1);
      default: h_end = HCW'(H_SYNC - 1);
    endcase
    case (v_seg_reg)
      SEG_BP:  v_end = VCW'(V_BACK_PORCH - 1);
      SEG_ACT: v_end = VCW'(V_ACTIVE - 1);
      SEG_FP:  v_end = VCW'(V_FRONT_PORCH - 1);
      default: v_end = VCW'(V_SYNC - 1);
    endcase
  end

  assign h_last    = (h_cnt_reg == h_end);
  assign v_last    = (v_cnt_reg == v_end);
  assign line_end  = h_last && (h_seg_reg == SEG_SYNC);
  assign frame_end = line_end && v_last && (v_seg_reg == SEG_SYNC);
  assign active    = (h_seg_reg == SEG_ACT) && (v_seg_reg == SEG_ACT);
  assign first     = active && (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign stream    = (mode_reg == 2'd0);
  assign sof_beat  = s_valid && s_sof;

  // Raster counters; mode only changes at the frame boundary.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      h_seg_reg <= SEG_BP;
      v_seg_reg <= SEG_BP;
      mode_reg  <= mode;
    end else if (enable) begin
      h_cnt_reg <= h_last ? '0 : h_cnt_reg + 1'b1;
      if (h_last)
        h_seg_reg <= h_seg_reg + 2'd1;
      if (line_end) begin
        v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
        if (v_last)
          v_seg_reg <= v_seg_reg + 2'd1;
      end
      if (frame_end)
        mode_reg <= mode;
    end
  end

  // Bar tracker: the last bar keeps counting so it absorbs the width remainder.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (enable) begin
      if (h_seg_reg != SEG_ACT) begin
        bar_cnt_reg <= '0;
        bar_idx_reg <= '0;
      end else if (bar_cnt_reg == BAR_LAST && bar_idx_reg != 3'd7) begin
        bar_cnt_reg <= '0;
        bar_idx_reg <= bar_idx_reg + 3'd1;
      end else begin
        bar_cnt_reg <= bar_cnt_reg + 1'b1;
      end
    end
  end

  assign bar_pixel = {{CW{!bar_idx_reg[1]}}, {CW{!bar_idx_reg[2]}}, {CW{!bar_idx_reg[0]}}};

  always_ff @(posedge clk) begin
    if (!resetn)
      state_reg <= UNLOCKED;
    else if (enable)
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!stream) begin
      state_next = UNLOCKED;
    end else begin
      case (state_reg)
        UNLOCKED: if (first && sof_beat) state_next = LOCKED;
        default:  if (active && (!s_valid || (s_sof && !first))) state_next = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    s_ready    = 1'b0;
    take_pixel = 1'b0;
    set_uf     = 1'b0;
    set_se     = 1'b0;
    if (resetn && enable) begin
      case (state_reg)
        UNLOCKED: begin
          // Drain stale beats but park on a start-of-frame until the raster reaches frame start.
          s_ready    = !sof_beat || (stream && first);
          take_pixel = stream && first && sof_beat;
        end
        default: begin
          s_ready = active;
          if (active) begin
            if (!s_valid)
              set_uf = 1'b1;
            else if (s_sof && !first)
              set_se = 1'b1;
            else
              take_pixel = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    pixel_next = '0;
    if (active) begin
      case (mode_reg)
        2'd0:    pixel_next = take_pixel ? s_pixel : '0;
        2'd1:    pixel_next = bar_pixel;
        2'd2:    pixel_next = solid_color;
        default: pixel_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      de_reg          <= 1'b0;
      hs_reg          <= !HS_POLARITY;
      vs_reg          <= !VS_POLARITY;
      pixel_reg       <= '0;
      frame_start_reg <= 1'b0;
      underflow_reg   <= 1'b0;
      sof_error_reg   <= 1'b0;
    end else if (enable) begin
      de_reg          <= active;
      hs_reg          <= (h_seg_reg == SEG_SYNC) ? HS_POLARITY : !HS_POLARITY;
      vs_reg          <= (v_seg_reg == SEG_SYNC) ? VS_POLARITY : !VS_POLARITY;
      pixel_reg       <= pixel_next;
      frame_start_reg <= first;
      underflow_reg   <= set_uf || (underflow_reg && !underflow_clr);
      sof_error_reg   <= set_se || (sof_error_reg && !underflow_clr);
    end
  end

  assign de          = de_reg;
  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign pixel       = pixel_reg;
  assign frame_start = frame_start_reg;
  assign underflow   = underflow_reg;
  assign sof_error   = sof_error_reg;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Scoreboard bench for dvi_timing_gen on a small 15x8 raster; the reference model
// works from the absolute position in the frame and queues one expected output per clock.
module tb_dvi_timing_gen;
  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 3;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 2;
  localparam int PW = 24;
  localparam int LINE = HA + HFP + HSY + HBP;
  localparam int FLINES = VA + VFP + VSY + VBP;
  localparam int FRAME = LINE * FLINES;
  localparam bit HSP = 1'b1, VSP = 1'b1;

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic          uf;
    logic          se;
    logic [PW-1:0] pixel;
  } obs_t;

  logic          clk = 1'b0;
  logic          resetn, enable, s_sof, s_valid, underflow_clr;
  logic [1:0]    mode;
  logic [PW-1:0] solid_color, s_pixel;
  logic          s_ready, de, hs, vs, frame_start, underflow, sof_error;
  logic [PW-1:0] pixel;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC(HSY), .H_BACK_PORCH(HBP),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC(VSY), .V_BACK_PORCH(VBP),
    .HS_POLARITY(HSP), .VS_POLARITY(VSP), .PIXEL_WIDTH(PW)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mode(mode), .solid_color(solid_color),
    .s_pixel(s_pixel), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
    .de(de), .hs(hs), .vs(vs), .pixel(pixel), .frame_start(frame_start),
    .underflow(underflow), .sof_error(sof_error), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  obs_t exp_q[$];
  int   t_q[$];
  int   n_checks = 0, n_fail = 0;
  bit   armed = 0;

  // Reference model state
  int         m_t = 0;
  bit         m_locked = 0, m_uf = 0, m_se = 0;
  logic [1:0] m_mode = 2'd3;
  obs_t       m_out;

  // Stimulus controls
  logic [1:0] mode_want = 2'd3;
  bit mode_noise = 0, clr_req = 0, drop_arm = 0, sof_arm = 0;
  bit rand_valid = 0, rand_clr = 0;
  int src_idx = 0;

  task automatic step(input bit rst_n, input bit en);
    int hx, ly, px, ln, bar;
    bit act, first, stream, h_syn, v_syn, sofb, rdy, set_uf, set_se, nl, dropped;
    logic [PW-1:0] pix;
    @(negedge clk);
    resetn = rst_n;
    enable = en;
    mode = (mode_noise && rst_n && m_t != FRAME - 1) ? 2'($urandom_range(0, 3)) : mode_want;
    solid_color = PW'($urandom);
    underflow_clr = clr_req || (rand_clr && $urandom_range(0, 49) == 0);
    clr_req = 0;
    dropped = drop_arm && (src_idx % 32 == 10);
    s_valid = !dropped && !(rand_valid && $urandom_range(0, 24) == 0);
    s_sof = (src_idx % 32 == 0) || (sof_arm && src_idx % 32 == 5);
    s_pixel = {8'(src_idx / 32), 16'(src_idx % 32)};
    if (dropped) drop_arm = 0;
    #1;
    rdy = 0;
    if (!rst_n) begin
      m_out = '{de: 1'b0, hs: !HSP, vs: !VSP, fs: 1'b0, uf: 1'b0, se: 1'b0, pixel: '0};
      m_t = 0; m_locked = 0; m_uf = 0; m_se = 0; m_mode = mode;
    end else if (en) begin
      hx = m_t % LINE;
      ly = m_t / LINE;
      px = hx - HBP;
      ln = ly - VBP;
      act    = (px >= 0 && px < HA) && (ln >= 0 && ln < VA);
      first  = act && px == 0 && ln == 0;
      h_syn  = hx >= HBP + HA + HFP;
      v_syn  = ly >= VBP + VA + VFP;
      stream = (m_mode == 2'd0);
      sofb   = s_valid && s_sof;
      rdy    = m_locked ? act : (!sofb || (stream && first));
      pix = '0; set_uf = 0; set_se = 0; nl = m_locked;
      case (m_mode)
        2'd0: begin
          if (!m_locked) begin
            if (first && sofb) begin pix = s_pixel; nl = 1; end
          end else if (act) begin
            if (!s_valid) begin set_uf = 1; nl = 0; end
            else if (s_sof && !first) begin set_se = 1; nl = 0; end
            else pix = s_pixel;
          end
        end
        2'd1: begin
          bar = (px >= 0) ? px / (HA / 8) : 0;
          if (bar > 7) bar = 7;
          pix = bar_rgb[bar];
        end
        2'd2: pix = solid_color;
        default: pix = '0;
      endcase
      if (!stream) nl = 0;
      m_uf = set_uf || (m_uf && !underflow_clr);
      m_se = set_se || (m_se && !underflow_clr);
      m_out = '{de: act, hs: h_syn ? HSP : !HSP, vs: v_syn ? VSP : !VSP, fs: first,
                uf: m_uf, se: m_se, pixel: act ? pix : '0};
      if (m_t == FRAME - 1) m_mode = mode;
      m_t = (m_t + 1) % FRAME;
      m_locked = nl;
    end
    n_checks++;
    if (s_ready !== rdy) begin
      n_fail++;
      $display("FAIL s_ready t=%0d got %b expected %b", m_t, s_ready, rdy);
    end
    exp_q.push_back(m_out);
    t_q.push_back(m_t);
    armed = 1;
    if (s_valid && rdy) begin
      if (sof_arm && src_idx % 32 == 5) sof_arm = 0;
      src_idx++;
    end
  endtask

  // Monitor: one registered output set per clock edge
  initial begin
    obs_t got, e;
    int   tt;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        tt = t_q.pop_front();
        got = {de, hs, vs, frame_start, underflow, sof_error, pixel};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs pos=%0d got de=%b hs=%b vs=%b fs=%b uf=%b se=%b px=%h expected de=%b hs=%b vs=%b fs=%b uf=%b se=%b px=%h",
                   tt, got.de, got.hs, got.vs, got.fs, got.uf, got.se, got.pixel,
                   e.de, e.hs, e.vs, e.fs, e.uf, e.se, e.pixel);
        end
      end else if (armed) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty got no expectation required one");
      end
    end
  end

  initial begin
    resetn = 0; enable = 0; mode = 2'd3; solid_color = '0;
    s_pixel = '0; s_sof = 0; s_valid = 0; underflow_clr = 0;

    // Black, bars and solid colour, with mode wiggled mid-frame
    mode_want = 2'd3;
    repeat (3) step(0, 1);
    mode_noise = 1;
    repeat (FRAME) step(1, 1);
    mode_want = 2'd1;
    repeat (FRAME) step(1, 1);
    mode_want = 2'd2;
    repeat (FRAME + 50) step(1, 1);

    // Mid-frame reset into stream mode; source always valid
    mode_want = 2'd0;
    repeat (2) step(0, 1);
    repeat (3 * FRAME) step(1, 1);

    // One missing beat at pixel 10, then relock next frame
    drop_arm = 1;
    repeat (2 * FRAME) step(1, 1);
    clr_req = 1;
    step(1, 1);
    repeat (FRAME) step(1, 1);

    // Stray start-of-frame on pixel 5
    sof_arm = 1;
    repeat (2 * FRAME) step(1, 1);
    clr_req = 1;
    step(1, 1);
    repeat (60) step(1, 1);

    // Freeze mid-active for 10 clocks
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_t == VBP * LINE + HBP + 4) break;
      step(1, 1);
    end
    repeat (10) step(1, 0);
    repeat (FRAME) step(1, 1);

    // Randomised enable gaps, valid drops, clears and per-frame modes
    rand_valid = 1;
    rand_clr = 1;
    for (int f = 0; f < 6; f++) begin
      mode_want = 2'($urandom_range(0, 3));
      repeat (FRAME) step(1, $urandom_range(0, 7) != 0);
    end
    rand_valid = 0;
    rand_clr = 0;
    mode_want = 2'd0;
    repeat (3 * FRAME) step(1, 1);

    @(posedge clk);
    #2;
    armed = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
